// File: rtl/csr_counters.sv
// Machine/user performance counter CSRs: mcycle, minstret and NUM_HPM event counters,
// with combinational read-back, privilege checking and read-only shadow detection.
module csr_counters #(
   parameter int XLEN        = 64,
   parameter int NUM_HPM     = 4,
   parameter int S_SUPPORTED = 1,
   parameter int U_SUPPORTED = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CSRCWriteM,
   input  logic              UngatedCSRCWriteM,
   input  logic [11:0]       CSRAdrM,
   input  logic [XLEN-1:0]   CSRWriteValM,
   input  logic              InstrRetiredM,
   input  logic [NUM_HPM-1:0] HPMEventM,
   input  logic [1:0]        PrivilegeModeM,
   input  logic [31:0]       MCOUNTINHIBIT_REGW,
   input  logic [31:0]       MCOUNTEREN_REGW,
   input  logic [31:0]       SCOUNTEREN_REGW,
   output logic [XLEN-1:0]   CSRCReadValM,
   output logic              IllegalCSRCAccessM,
   output logic              IllegalCSRCWriteReadonlyM
);

   localparam int NCNT = NUM_HPM + 3;
   localparam logic [5:0] NCNT_W = 6'(NCNT);

   logic        is_m_s;
   logic        is_u_s;
   logic        high_s;
   logic        implemented_s;
   logic        priv_ok_s;
   logic        illegal_s;
   logic        wr_s;
   logic [4:0]  idx_s;
   logic [63:0] wval_s;
   logic [63:0] sel_s;
   wire  [63:0] cnt_s [NCNT];

   // Address decode: bank, half and counter index
   always_comb begin
      is_m_s        = (CSRAdrM[11:8] == 4'hB);
      is_u_s        = (CSRAdrM[11:8] == 4'hC);
      high_s        = CSRAdrM[7];
      idx_s         = CSRAdrM[4:0];
      implemented_s = (is_m_s || is_u_s) && (CSRAdrM[6:5] == 2'b00) &&
                      ({1'b0, idx_s} < NCNT_W) && (idx_s != 5'd1) &&
                      (!high_s || (XLEN == 32));
   end

   // Privilege gating: machine bank is M-only, user shadows follow the enable masks
   always_comb begin
      priv_ok_s = 1'b1;
      if (is_u_s) begin
         if (U_SUPPORTED == 0) begin
            priv_ok_s = 1'b0;
         end else begin
            case (PrivilegeModeM)
               2'b11:   priv_ok_s = 1'b1;
               2'b01:   priv_ok_s = MCOUNTEREN_REGW[idx_s];
               default: priv_ok_s = MCOUNTEREN_REGW[idx_s] &&
                                    ((S_SUPPORTED == 0) || SCOUNTEREN_REGW[idx_s]);
            endcase
         end
      end else if (is_m_s) begin
         priv_ok_s = (PrivilegeModeM == 2'b11);
      end else begin
         priv_ok_s = 1'b1;
      end
   end

   assign illegal_s                 = !implemented_s || !priv_ok_s;
   assign IllegalCSRCAccessM        = illegal_s;
   assign IllegalCSRCWriteReadonlyM = UngatedCSRCWriteM && is_u_s && (CSRAdrM[7:0] < 8'hA0);
   // Only the machine bank is writable; shadow writes never reach a counter
   assign wr_s                      = CSRCWriteM && is_m_s && !illegal_s;
   assign wval_s                    = 64'(CSRWriteValM);

   // Read mux: unimplemented addresses return zero
   always_comb begin
      sel_s = 64'd0;
      for (int i = 0; i < NCNT; i++) begin
         sel_s = (implemented_s && (idx_s == 5'(i))) ? cnt_s[i] : sel_s;
      end
      CSRCReadValM = high_s ? XLEN'(sel_s >> 32) : XLEN'(sel_s);
   end

   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      if (g == 1) begin : g_time
         assign cnt_s[g] = 64'd0;
      end else begin : g_reg
         logic        inc_s;
         logic        hit_s;
         logic [63:0] cnt_r;

         if (g == 0) begin : g_cycle
            assign inc_s = !MCOUNTINHIBIT_REGW[0];
         end else if (g == 2) begin : g_instret
            assign inc_s = InstrRetiredM && !MCOUNTINHIBIT_REGW[2];
         end else begin : g_hpm
            assign inc_s = HPMEventM[g-3] && !MCOUNTINHIBIT_REGW[g];
         end

         assign hit_s    = wr_s && (idx_s == 5'(g));
         assign cnt_s[g] = cnt_r;

         // Counter state: a write in the same cycle suppresses the increment
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_r <= 64'd0;
            end else if (hit_s) begin
               if (XLEN == 64) begin
                  cnt_r <= wval_s;
               end else if (high_s) begin
                  cnt_r <= {wval_s[31:0], cnt_r[31:0]};
               end else begin
                  cnt_r <= {cnt_r[63:32], wval_s[31:0]};
               end
            end else if (inc_s) begin
               cnt_r <= cnt_r + 64'd1;
            end
         end
      end
   end

   wire unused_s = &{1'b0, MCOUNTINHIBIT_REGW, MCOUNTEREN_REGW, SCOUNTEREN_REGW, wval_s};

endmodule

// File: tb/tb_csr_counters.sv
// Bench for csr_counters: RV64 and RV32 instances checked against an array-based counter model
// through directed scenarios followed by a randomized phase.
module tb_csr_counters;

   localparam int NH = 4;
   localparam int NC = NH + 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          we64, we32, uwe64, uwe32;
   logic [11:0]   adr64, adr32;
   logic [63:0]   wv64;
   logic [31:0]   wv32;
   logic          ret;
   logic [NH-1:0] ev;
   logic [1:0]    priv;
   logic [31:0]   inh, men, sen;
   logic [63:0]   rd64;
   logic [31:0]   rd32;
   logic          ill64, ill32, ro64, ro32;

   logic [63:0]   m [2][NC];
   int            checks = 0;
   int            errors = 0;
   logic [11:0]   alist [20];

   always #5 clk = ~clk;

   csr_counters #(.XLEN(64), .NUM_HPM(NH), .S_SUPPORTED(1), .U_SUPPORTED(1)) u64 (
      .clk(clk), .reset(reset), .CSRCWriteM(we64), .UngatedCSRCWriteM(uwe64),
      .CSRAdrM(adr64), .CSRWriteValM(wv64), .InstrRetiredM(ret), .HPMEventM(ev),
      .PrivilegeModeM(priv), .MCOUNTINHIBIT_REGW(inh), .MCOUNTEREN_REGW(men),
      .SCOUNTEREN_REGW(sen), .CSRCReadValM(rd64), .IllegalCSRCAccessM(ill64),
      .IllegalCSRCWriteReadonlyM(ro64));

   csr_counters #(.XLEN(32), .NUM_HPM(NH), .S_SUPPORTED(1), .U_SUPPORTED(1)) u32 (
      .clk(clk), .reset(reset), .CSRCWriteM(we32), .UngatedCSRCWriteM(uwe32),
      .CSRAdrM(adr32), .CSRWriteValM(wv32), .InstrRetiredM(ret), .HPMEventM(ev),
      .PrivilegeModeM(priv), .MCOUNTINHIBIT_REGW(inh), .MCOUNTEREN_REGW(men),
      .SCOUNTEREN_REGW(sen), .CSRCReadValM(rd32), .IllegalCSRCAccessM(ill32),
      .IllegalCSRCWriteReadonlyM(ro32));

   // k = 0 models the RV64 instance, k = 1 the RV32 instance
   function automatic int cidx(logic [11:0] a);
      return int'(a[7:0]) % 128;
   endfunction

   function automatic bit impl(int k, logic [11:0] a);
      int i;
      if (a[11:8] != 4'hB && a[11:8] != 4'hC) return 1'b0;
      if (int'(a[7:0]) >= 128 && k == 0) return 1'b0;
      i = cidx(a);
      return (i != 1) && (i < NC);
   endfunction

   function automatic bit illegal(int k, logic [11:0] a);
      int i;
      if (!impl(k, a)) return 1'b1;
      i = cidx(a);
      if (a[11:8] == 4'hB) return priv != 2'b11;
      if (priv == 2'b11) return 1'b0;
      if (priv == 2'b01) return !men[i];
      return !men[i] || !sen[i];
   endfunction

   function automatic logic [63:0] exp_rd(int k, logic [11:0] a);
      logic [63:0] v;
      if (!impl(k, a)) return 64'd0;
      v = m[k][cidx(a)];
      if (int'(a[7:0]) >= 128) v = v / 64'h1_0000_0000;
      if (k == 1) v = v % 64'h1_0000_0000;
      return v;
   endfunction

   function automatic bit exp_ro(logic uwe, logic [11:0] a);
      return uwe && (a >= 12'hC00) && (a <= 12'hC9F);
   endfunction

   task automatic model_step(int k, bit we, logic [11:0] a, logic [63:0] wv);
      bit wr;
      bit inc;
      wr = we && (a[11:8] == 4'hB) && !illegal(k, a);
      for (int i = 0; i < NC; i++) begin
         if (i == 1) continue;
         if (wr && cidx(a) == i) begin
            if (k == 0) m[k][i] = wv;
            else if (int'(a[7:0]) >= 128) m[k][i] = {wv[31:0], m[k][i][31:0]};
            else m[k][i] = {m[k][i][63:32], wv[31:0]};
         end else begin
            if (i == 0) inc = !inh[0];
            else if (i == 2) inc = ret && !inh[2];
            else inc = ev[i-3] && !inh[i];
            m[k][i] = m[k][i] + (inc ? 64'd1 : 64'd0);
         end
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NC; i++) m[k][i] = 64'd0;
   endtask

   task automatic cyc();
      if (reset) begin
         model_step(0, we64, adr64, wv64);
         model_step(1, we32, adr32, {32'd0, wv32});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(string tag);
      chk({tag, "/rd64"}, rd64, exp_rd(0, adr64));
      chk({tag, "/ill64"}, {63'd0, ill64}, {63'd0, illegal(0, adr64)});
      chk({tag, "/ro64"}, {63'd0, ro64}, {63'd0, exp_ro(uwe64, adr64)});
      chk({tag, "/rd32"}, {32'd0, rd32}, exp_rd(1, adr32));
      chk({tag, "/ill32"}, {63'd0, ill32}, {63'd0, illegal(1, adr32)});
      chk({tag, "/ro32"}, {63'd0, ro32}, {63'd0, exp_ro(uwe32, adr32)});
   endtask

   task automatic look(string tag, logic [11:0] a);
      adr64 = a;
      adr32 = a;
      #1;
      chk_bus(tag);
   endtask

   initial begin
      reset = 1'b0; we64 = 1'b0; we32 = 1'b0; uwe64 = 1'b0; uwe32 = 1'b0;
      adr64 = 12'hB00; adr32 = 12'hB00; wv64 = 64'd0; wv32 = 32'd0;
      ret = 1'b0; ev = '0; priv = 2'b11; inh = 32'd0; men = 32'd0; sen = 32'd0;
      clear_model();
      alist = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB07, 12'hB01,
                12'hB80, 12'hB82, 12'hB86, 12'hC00, 12'hC01, 12'hC02, 12'hC05, 12'hC80,
                12'hC83, 12'hC9F, 12'hCA0, 12'h300};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      look("rst", 12'hB00);
      chk("rst_zero", rd64, 64'd0);
      reset = 1'b1;
      repeat (10) cyc();
      look("run10", 12'hB00);
      chk("mcycle10", rd64, 64'd10);
      chk("mcycle10_32", {32'd0, rd32}, 64'd10);
      look("run10_ir", 12'hB02);
      chk("minstret0", rd64, 64'd0);

      // Asynchronous clear mid-cycle
      #2 reset = 1'b0;
      clear_model();
      look("async_clr", 12'hB00);
      chk("async_zero", rd64, 64'd0);
      #1 reset = 1'b1;

      // Inhibit then resume; retirements counted
      inh = 32'h1; ret = 1'b1;
      cyc();
      ret = 1'b0;
      repeat (4) cyc();
      inh = 32'h0; ret = 1'b1;
      repeat (3) cyc();
      ret = 1'b0;
      look("inh_cyc", 12'hB00);
      chk("mcycle3", rd64, 64'd3);
      look("inh_ir", 12'hB02);
      chk("minstret4", rd64, 64'd4);

      // Write beats a same-cycle retirement
      adr64 = 12'hB02; adr32 = 12'hB02; wv64 = 64'h1234; wv32 = 32'h1234;
      we64 = 1'b1; we32 = 1'b1; ret = 1'b1;
      cyc();
      we64 = 1'b0; we32 = 1'b0;
      look("wr_ir", 12'hB02);
      chk("wr1234", rd64, 64'h1234);
      chk("wr1234_32", {32'd0, rd32}, 64'h1234);
      cyc();
      ret = 1'b0;
      look("wr_ir_inc", 12'hB02);
      chk("ir1235", rd64, 64'h1235);

      // RV64 full wrap
      adr64 = 12'hB00; wv64 = 64'hFFFF_FFFF_FFFF_FFFF; we64 = 1'b1;
      cyc();
      we64 = 1'b0;
      look("wrap_pre", 12'hB00);
      chk("all_ones", rd64, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc();
      look("wrap_post", 12'hB00);
      chk("wrap0", rd64, 64'd0);

      // RV32 low-half carry into high half
      adr32 = 12'hB00; wv32 = 32'hFFFF_FFFF; we32 = 1'b1;
      cyc();
      adr32 = 12'hB80; wv32 = 32'h0;
      cyc();
      we32 = 1'b0;
      cyc();
      look("rv32_lo", 12'hB00);
      chk("rv32_lo0", {32'd0, rd32}, 64'd0);
      look("rv32_hi", 12'hB80);
      chk("rv32_hi1", {32'd0, rd32}, 64'd1);
      chk("rv64_hi_illegal", {63'd0, ill64}, 64'd1);

      // User-mode shadow access
      priv = 2'b00; men = 32'h1; sen = 32'h0;
      look("u_nosen", 12'hC00);
      chk("u_nosen_ill", {63'd0, ill64}, 64'd1);
      sen = 32'h1;
      look("u_sen", 12'hC00);
      chk("u_sen_ok", {63'd0, ill64}, 64'd0);
      adr64 = 12'hC02; adr32 = 12'hC02; uwe64 = 1'b1; uwe32 = 1'b1;
      we64 = 1'b1; we32 = 1'b1; wv64 = 64'hDEAD; wv32 = 32'hDEAD;
      #1;
      chk_bus("ro_try");
      chk("ro_flag", {63'd0, ro64}, 64'd1);
      cyc();
      we64 = 1'b0; we32 = 1'b0; uwe64 = 1'b0; uwe32 = 1'b0; priv = 2'b11;
      look("ro_after", 12'hB02);
      chk("ro_unchanged", rd64, 64'h1235);
      priv = 2'b01; men = 32'h0;
      look("s_nomen", 12'hC00);
      look("s_mbank", 12'hB00);
      priv = 2'b11;

      // HPM event counting and out-of-range index
      ev = 4'b0001;
      repeat (7) cyc();
      ev = '0;
      look("hpm3", 12'hB03);
      chk("hpm3_7", rd64, 64'd7);
      look("hpm_oor", 12'hB07);
      chk("hpm_oor_ill", {63'd0, ill64}, 64'd1);
      chk("hpm_oor_zero", rd64, 64'd0);
      look("time_shadow", 12'hC01);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [11:0] a;
         bit w;
         case ($urandom_range(0, 3))
            0:       priv = 2'b01;
            1:       priv = 2'b00;
            default: priv = 2'b11;
         endcase
         inh = $urandom & $urandom;
         ret = 1'($urandom);
         ev = NH'($urandom);
         men = $urandom;
         sen = $urandom;
         a = alist[$urandom_range(0, 19)];
         adr64 = a;
         adr32 = a;
         w = ($urandom_range(0, 3) == 0);
         uwe64 = w;
         uwe32 = w;
         we64 = w && (a[11:8] == 4'hB) && !illegal(0, a);
         we32 = w && (a[11:8] == 4'hB) && !illegal(1, a);
         wv64 = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
         wv32 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
         #1;
         chk_bus("rnd");
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
